// File: rtl/stream_mux_n.sv
// stream_mux_n: N:1 valid/ready stream multiplexer with a registered output stage,
// direct-select or round-robin grant. Optional packet locking via STREAM_MUX_PKT_LOCK_EN.
module stream_mux_n #(
  parameter int N      = 4,
  parameter int WIDTH  = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [N-1:0]       in_last,
  output logic               out_last,
`endif
  input  logic               out_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_ch,
  output logic               sel_err
);

  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= N) begin
      sum = sum - N;
    end else begin
      sum = sum;
    end
    return SEL_W'(sum);
  endfunction

  logic             sel_oob_s;
  logic             load_s;
  logic             xfer_s;
  logic             grant_valid_s;
  logic             beat_last_s;
  logic [SEL_W-1:0] grant_s;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             sel_err_q, sel_err_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

`ifdef STREAM_MUX_PKT_LOCK_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} lock_state_e;
  lock_state_e      state_q, state_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic             out_last_q, out_last_d;
  assign beat_last_s = in_last[grant_s];
  assign out_last    = out_last_q;
`else
  assign beat_last_s = 1'b1;
`endif

  // Grant selection: direct index or first valid channel at/after rr_ptr.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = '0;
    sel_oob_s     = ({1'b0, sel} >= N_EXT);
    if (mode == 1'b0) begin
      if (!sel_oob_s) begin
        grant_valid_s = 1'b1;
        grant_s       = sel;
      end else begin
        grant_valid_s = 1'b0;
      end
    end else begin
      // Descending scan so the nearest channel to rr_ptr is written last and wins.
      for (int k = N - 1; k >= 0; k--) begin
        if (in_valid[wrap_inc(rr_ptr_q, k)]) begin
          grant_valid_s = 1'b1;
          grant_s       = wrap_inc(rr_ptr_q, k);
        end else begin
          grant_valid_s = grant_valid_s;
        end
      end
    end
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (state_q == ST_LOCKED) begin
      grant_valid_s = 1'b1;
      grant_s       = lock_ch_q;
    end else begin
      grant_valid_s = grant_valid_s;
    end
`endif
  end

  // Handshake: one-hot ready toward the granted channel when the output can load.
  always_comb begin
    load_s   = !out_valid_q || out_ready;
    in_ready = '0;
    if (rst_n && load_s && grant_valid_s) begin
      in_ready[grant_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
    xfer_s = |(in_valid & in_ready);
  end

  // Output register and round-robin pointer next state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    sel_err_d   = (mode == 1'b0) && sel_oob_s;
    if (load_s) begin
      if (xfer_s) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data[grant_s*WIDTH +: WIDTH];
        out_ch_d    = grant_s;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
    if (xfer_s && mode && beat_last_s) begin
      rr_ptr_d = wrap_inc(grant_s, 1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  // Packet lock: hold the grant on a channel until its last beat transfers.
  always_comb begin
    state_d    = state_q;
    lock_ch_d  = lock_ch_q;
    out_last_d = out_last_q;
    if (xfer_s) begin
      out_last_d = in_last[grant_s];
      case (state_q)
        ST_IDLE: begin
          if (!in_last[grant_s]) begin
            state_d   = ST_LOCKED;
            lock_ch_d = grant_s;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (in_last[grant_s]) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Packet lock state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lock_ch_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_ch_q  <= lock_ch_d;
      out_last_q <= out_last_d;
    end
  end
`endif

  // Output stage and arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      sel_err_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      sel_err_q   <= sel_err_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: directed vector table, reset corners, an N=3 instance
// and a randomized run against a rule-level reference model.
module tb_stream_mux_n;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mode = 1'b0;
  logic [SW-1:0]  sel = 2'd0;
  logic [N-1:0]   in_valid = 4'b0000;
  logic [N*W-1:0] in_data = 32'h0;
  logic           out_ready = 1'b0;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           sel_err;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [N-1:0]   in_last = 4'b1111;
  logic           out_last;
  logic [2:0]     in_last3 = 3'b111;
  logic           out_last3;
`endif

  logic        mode3 = 1'b0;
  logic [1:0]  sel3 = 2'd0;
  logic [2:0]  vld3 = 3'b000;
  logic [23:0] data3 = 24'h0;
  logic        ordy3 = 1'b1;
  logic [2:0]  rdy3;
  logic        ov3;
  logic [7:0]  od3;
  logic [1:0]  ch3;
  logic        err3;

  stream_mux_n #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .sel_err(sel_err));

  stream_mux_n #(.N(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_valid(vld3),
    .in_data(data3), .in_ready(rdy3),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last(in_last3), .out_last(out_last3),
`endif
    .out_ready(ordy3), .out_valid(ov3), .out_data(od3),
    .out_ch(ch3), .sel_err(err3));

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        md;
    logic [1:0]  sl;
    logic [3:0]  vld;
    logic [31:0] dat;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_ch;
  } vec_t;
  vec_t tbl[21];

  // reference model state
  bit         m_valid;
  logic [7:0] m_data;
  int         m_ch;
  int         m_rr;
  bit         m_err;

  function automatic int ref_grant(input logic md, input int s, input logic [N-1:0] v, input int rr);
    if (md == 1'b0) return (s < N) ? s : -1;
    for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_n3_out_valid", ov3, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_valid = 0; m_data = 8'h00; m_ch = 0; m_rr = 0; m_err = 0;
  endtask

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [3:0]  lk_vld [4] = '{4'b0010, 4'b0011, 4'b0011, 4'b0011};
  logic [3:0]  lk_last[4] = '{4'b0000, 4'b0000, 4'b0010, 4'b1111};
  logic [31:0] lk_dat [4] = '{32'h0000A100, 32'h0000A2F0, 32'h0000A3F0, 32'h0000A4F0};
  logic [3:0]  lk_rdy [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0001};
  logic [7:0]  lk_od  [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hF0};
  logic [1:0]  lk_ch  [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
  logic        lk_ol  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif

  initial begin
    tbl[0]  = '{1'b0, 2'd2, 4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tbl[1]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[2]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tbl[3]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tbl[5]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[6]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tbl[7]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tbl[8]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tbl[9]  = '{1'b1, 2'd0, 4'b1111, 32'h44434233, 1'b1, 4'b0001, 1'b1, 8'h33, 2'd0};
    tbl[10] = '{1'b1, 2'd0, 4'b1111, 32'h44434233, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd0};
    tbl[11] = '{1'b1, 2'd0, 4'b1111, 32'h44434233, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd0};
    tbl[12] = '{1'b1, 2'd0, 4'b1111, 32'h44434233, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd0};
    tbl[13] = '{1'b1, 2'd0, 4'b1111, 32'h44434233, 1'b1, 4'b0010, 1'b1, 8'h42, 2'd1};
    tbl[14] = '{1'b1, 2'd0, 4'b1010, 32'hB3B2B1B0, 1'b1, 4'b1000, 1'b1, 8'hB3, 2'd3};
    tbl[15] = '{1'b1, 2'd0, 4'b1010, 32'hB3B2B1B0, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1};
    tbl[16] = '{1'b1, 2'd0, 4'b0000, 32'hB3B2B1B0, 1'b1, 4'b0000, 1'b0, 8'hB1, 2'd1};
    tbl[17] = '{1'b0, 2'd1, 4'b0000, 32'hB3B2B1B0, 1'b1, 4'b0010, 1'b0, 8'hB1, 2'd1};
    tbl[18] = '{1'b0, 2'd1, 4'b0010, 32'h0000C100, 1'b1, 4'b0010, 1'b1, 8'hC1, 2'd1};
    tbl[19] = '{1'b1, 2'd0, 4'b1111, 32'hB3B2B1B0, 1'b1, 4'b0100, 1'b1, 8'hB2, 2'd2};
    tbl[20] = '{1'b0, 2'd3, 4'b1000, 32'h000000FF, 1'b0, 4'b0000, 1'b1, 8'hB2, 2'd2};

    // reset state: ready forced low even though a direct grant would exist
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_ch", out_ch, 0);
    check("reset_sel_err", sel_err, 0);
    check("reset_n3_out_valid", ov3, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      mode = tbl[i].md; sel = tbl[i].sl; in_valid = tbl[i].vld;
      in_data = tbl[i].dat; out_ready = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
      check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_od);
      check($sformatf("tbl%0d_out_ch", i), out_ch, tbl[i].e_ch);
      check($sformatf("tbl%0d_sel_err", i), sel_err, 0);
    end

    // out_valid is 1 here: asynchronous mid-stream reset
    pulse_reset();

`ifdef STREAM_MUX_PKT_LOCK_EN
    for (int i = 0; i < 4; i++) begin
      mode = 1'b1; out_ready = 1'b1; in_valid = lk_vld[i]; in_last = lk_last[i]; in_data = lk_dat[i];
      @(negedge clk);
      check($sformatf("lock%0d_in_ready", i), in_ready, lk_rdy[i]);
      @(posedge clk);
      #1;
      check($sformatf("lock%0d_out_data", i), out_data, lk_od[i]);
      check($sformatf("lock%0d_out_ch", i), out_ch, lk_ch[i]);
      check($sformatf("lock%0d_out_last", i), out_last, lk_ol[i]);
    end
    in_last = 4'b1111;
    pulse_reset();
`endif

    for (int c = 0; c < 400; c++) begin
      automatic int g;
      automatic logic [3:0] one4 = 4'b0001;
      automatic logic [3:0] exp_rdy;
      mode = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom_range(0, 15));
      in_data = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      g = ref_grant(mode, int'(sel), in_valid, m_rr);
      exp_rdy = (g >= 0 && (!m_valid || out_ready)) ? (one4 << g) : 4'b0000;
      @(negedge clk);
      check("rand_in_ready", in_ready, exp_rdy);
      @(posedge clk);
      if (!m_valid || out_ready) begin
        if (g >= 0 && in_valid[g]) begin
          m_valid = 1; m_data = in_data[g*8 +: 8]; m_ch = g;
          if (mode) m_rr = (g + 1) % N;
        end else m_valid = 0;
      end
      m_err = (mode == 1'b0) && (int'(sel) >= N);
      #1;
      check("rand_out_valid", out_valid, m_valid);
      check("rand_out_data", out_data, m_data);
      check("rand_out_ch", out_ch, m_ch);
      check("rand_sel_err", sel_err, m_err);
    end

    // N=3 instance: out-of-range select
    mode3 = 1'b0; sel3 = 2'd0; vld3 = 3'b001; data3 = 24'h00005A; ordy3 = 1'b1;
    @(negedge clk);
    check("n3_s1_in_ready", rdy3, 3'b001);
    @(posedge clk); #1;
    check("n3_s1_out_valid", ov3, 1);
    check("n3_s1_out_data", od3, 8'h5A);
    check("n3_s1_sel_err", err3, 0);
    sel3 = 2'd3; vld3 = 3'b111; data3 = 24'h0;
    @(negedge clk);
    check("n3_s2_in_ready", rdy3, 3'b000);
    @(posedge clk); #1;
    check("n3_s2_sel_err", err3, 1);
    check("n3_s2_out_valid", ov3, 0);
    check("n3_s2_out_data", od3, 8'h5A);
    mode3 = 1'b1; vld3 = 3'b100; data3 = 24'h7E0000;
    @(negedge clk);
    check("n3_s3_in_ready", rdy3, 3'b100);
    @(posedge clk); #1;
    check("n3_s3_sel_err", err3, 0);
    check("n3_s3_out_valid", ov3, 1);
    check("n3_s3_out_data", od3, 8'h7E);
    check("n3_s3_out_ch", ch3, 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
